// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL bring-up sequencer: state encoding,
// registered output bundle and counter sizing helper.
package pll_seq_pkg;

   localparam int DEF_RESET_CYCLES  = 16;
   localparam int DEF_LOCK_TIMEOUT  = 16000;
   localparam int DEF_STABLE_CYCLES = 1024;
   localparam int DEF_MAX_RETRIES   = 3;
   localparam int LOST_W            = 8;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_WAIT   = 3'd1,
      S_STABLE = 3'd2,
      S_RUN    = 3'd3,
      S_FAULT  = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic pll_resetb;
      logic sys_reset_n;
      logic ready;
      logic fault;
   } seq_out_t;

   localparam seq_out_t OUTS_OFF = '{pll_resetb: 1'b0, sys_reset_n: 1'b0, ready: 1'b0, fault: 1'b0};

   // Bits needed to hold 0..n-1, never less than one
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Output levels while resident in a given state
   function automatic seq_out_t state_outputs(input seq_state_t st);
      seq_out_t o;
      o = OUTS_OFF;
      case (st)
         S_WAIT, S_STABLE: o.pll_resetb = 1'b1;
         S_RUN: begin
            o.pll_resetb  = 1'b1;
            o.sys_reset_n = 1'b1;
            o.ready       = 1'b1;
         end
         S_FAULT: o.fault = 1'b1;
         default: o = OUTS_OFF;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/pll_sequencer_if.sv
// PLL-facing and system-facing signals of the sequencer; slave is the sequencer side.
interface pll_sequencer_if;
   import pll_seq_pkg::*;

   logic              pll_locked;
   logic              restart;
   logic              pll_resetb;
   logic              sys_reset_n;
   logic              ready;
   logic              fault;
   logic [LOST_W-1:0] lost_count;

   modport master (
      output pll_locked,
      output restart,
      input  pll_resetb,
      input  sys_reset_n,
      input  ready,
      input  fault,
      input  lost_count
   );

   modport slave (
      input  pll_locked,
      input  restart,
      output pll_resetb,
      output sys_reset_n,
      output ready,
      output fault,
      output lost_count
   );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta_r;
   logic q_r;

   // Two-stage capture of the asynchronous input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b0;
         q_r    <= 1'b0;
      end else begin
         meta_r <= d;
         q_r    <= meta_r;
      end
   end

   assign q = q_r;
endmodule

// File: rtl/pll_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a stable lock with bounded
// retries, then releases the PLL-domain reset and watches for lock loss.
module pll_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input logic            clock_in,
   input logic            reset_n,
   pll_sequencer_if.slave bus
);
   localparam int RCW = cnt_width(RESET_CYCLES);
   localparam int TW  = cnt_width(LOCK_TIMEOUT);
   localparam int SW  = cnt_width(STABLE_CYCLES);
   // Retry counter must reach MAX_RETRIES itself, not MAX_RETRIES-1
   localparam int RW  = cnt_width(MAX_RETRIES + 1);

   localparam logic [RCW-1:0]    RESET_LAST  = RCW'(RESET_CYCLES - 1);
   localparam logic [RCW-1:0]    RESET_ONE   = RCW'(1);
   localparam logic [TW-1:0]     TIMER_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0]     TIMER_ONE   = TW'(1);
   localparam logic [SW-1:0]     STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0]     STABLE_ONE  = SW'(1);
   localparam logic [RW-1:0]     RETRY_MAX   = RW'(MAX_RETRIES);
   localparam logic [RW-1:0]     RETRY_ONE   = RW'(1);
   localparam logic [LOST_W-1:0] LOST_MAX    = {LOST_W{1'b1}};
   localparam logic [LOST_W-1:0] LOST_ONE    = LOST_W'(1);

   logic              lock_s;
   seq_state_t        state_r;
   seq_out_t          outs_r;
   logic [RCW-1:0]    reset_cnt_r;
   logic [TW-1:0]     timer_r;
   logic [SW-1:0]     stable_cnt_r;
   logic [RW-1:0]     retry_cnt_r;
   logic [LOST_W-1:0] lost_count_r;

   sync2 u_lock_sync (
      .clk   (clock_in),
      .rst_n (reset_n),
      .d     (bus.pll_locked),
      .q     (lock_s)
   );

   // Sequencer FSM; outputs are registered alongside the state they belong to
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= S_RESET;
         outs_r       <= OUTS_OFF;
         reset_cnt_r  <= '0;
         timer_r      <= '0;
         stable_cnt_r <= '0;
         retry_cnt_r  <= '0;
         lost_count_r <= '0;
      end else if (bus.restart) begin
         state_r      <= S_RESET;
         outs_r       <= state_outputs(S_RESET);
         reset_cnt_r  <= '0;
         timer_r      <= '0;
         stable_cnt_r <= '0;
         retry_cnt_r  <= '0;
      end else begin
         case (state_r)
            S_RESET: begin
               if (reset_cnt_r == RESET_LAST) begin
                  state_r     <= S_WAIT;
                  outs_r      <= state_outputs(S_WAIT);
                  reset_cnt_r <= '0;
                  timer_r     <= '0;
               end else begin
                  reset_cnt_r <= reset_cnt_r + RESET_ONE;
               end
            end
            S_WAIT, S_STABLE: begin
               // Timeout outranks the promotion to S_RUN in the same cycle
               if (timer_r == TIMER_LAST) begin
                  timer_r      <= '0;
                  stable_cnt_r <= '0;
                  if (retry_cnt_r < RETRY_MAX) begin
                     retry_cnt_r <= retry_cnt_r + RETRY_ONE;
                     state_r     <= S_RESET;
                     outs_r      <= state_outputs(S_RESET);
                  end else begin
                     state_r <= S_FAULT;
                     outs_r  <= state_outputs(S_FAULT);
                  end
               end else begin
                  timer_r <= timer_r + TIMER_ONE;
                  if (state_r == S_WAIT) begin
                     if (lock_s) begin
                        state_r      <= S_STABLE;
                        outs_r       <= state_outputs(S_STABLE);
                        stable_cnt_r <= '0;
                     end
                  end else if (!lock_s) begin
                     state_r      <= S_WAIT;
                     outs_r       <= state_outputs(S_WAIT);
                     stable_cnt_r <= '0;
                  end else if (stable_cnt_r == STABLE_LAST) begin
                     state_r      <= S_RUN;
                     outs_r       <= state_outputs(S_RUN);
                     stable_cnt_r <= '0;
                  end else begin
                     stable_cnt_r <= stable_cnt_r + STABLE_ONE;
                  end
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  state_r     <= S_RESET;
                  outs_r      <= state_outputs(S_RESET);
                  reset_cnt_r <= '0;
                  retry_cnt_r <= '0;
                  if (lost_count_r != LOST_MAX) begin
                     lost_count_r <= lost_count_r + LOST_ONE;
                  end
               end
            end
            S_FAULT: begin
               state_r <= S_FAULT;
               outs_r  <= state_outputs(S_FAULT);
            end
            default: begin
               state_r     <= S_RESET;
               outs_r      <= state_outputs(S_RESET);
               reset_cnt_r <= '0;
            end
         endcase
      end
   end

   assign bus.pll_resetb  = outs_r.pll_resetb;
   assign bus.sys_reset_n = outs_r.sys_reset_n;
   assign bus.ready       = outs_r.ready;
   assign bus.fault       = outs_r.fault;
   assign bus.lost_count  = lost_count_r;
endmodule

// File: tb/tb_pll_sequencer.sv
// Self-checking bench for pll_sequencer: directed vector table, hand-written
// corner sequences and random lock/restart traffic against a phase-level model.
module tb_pll_sequencer;
   localparam int RC = 16;
   localparam int LT = 600;
   localparam int SC = 32;
   localparam int MR = 3;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   pll_sequencer_if bus ();

   pll_sequencer #(
      .RESET_CYCLES  (RC),
      .LOCK_TIMEOUT  (LT),
      .STABLE_CYCLES (SC),
      .MAX_RETRIES   (MR)
   ) dut (
      .clock_in (clk),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Reference model: phases and elapsed-cycle arithmetic
   typedef enum int {M_HOLD, M_SEEK, M_UP, M_DEAD} mphase_t;
   mphase_t m_phase;
   int      m_n, m_streak, m_retries, m_lost;
   logic    m_s1, m_s2;

   function automatic void model_reset();
      m_phase = M_HOLD; m_n = 0; m_streak = 0; m_retries = 0; m_lost = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
   endfunction

   function automatic void model_edge(input logic locked, input logic rst_req);
      logic lk;
      lk = m_s2;
      m_s2 = m_s1;
      m_s1 = locked;
      if (rst_req) begin
         m_phase = M_HOLD; m_n = 0; m_retries = 0;
      end else begin
         case (m_phase)
            M_HOLD: begin
               m_n++;
               if (m_n == RC) begin m_phase = M_SEEK; m_n = 0; m_streak = 0; end
            end
            M_SEEK: begin
               m_n++;
               m_streak = lk ? m_streak + 1 : 0;
               if (m_n == LT) begin
                  m_n = 0;
                  if (m_retries < MR) begin m_retries++; m_phase = M_HOLD; end
                  else m_phase = M_DEAD;
               end else if (m_streak == SC + 1) begin
                  m_phase = M_UP;
               end
            end
            M_UP: begin
               if (!lk) begin
                  m_phase = M_HOLD; m_n = 0; m_retries = 0;
                  if (m_lost < 255) m_lost++;
               end
            end
            default: ;
         endcase
      end
   endfunction

   function automatic logic [11:0] model_outs();
      logic up;
      up = (m_phase == M_UP);
      return {(m_phase == M_SEEK) || up, up, up, m_phase == M_DEAD, 8'(m_lost)};
   endfunction

   function automatic logic [11:0] dut_outs();
      return {bus.pll_resetb, bus.sys_reset_n, bus.ready, bus.fault, bus.lost_count};
   endfunction

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (resetb,sys_rst_n,ready,fault,lost)", name, act, exp);
   endtask

   task automatic step();
      model_edge(bus.pll_locked, bus.restart);
      @(posedge clk);
      #1;
      check("cycle", dut_outs(), model_outs());
   endtask

   typedef struct {
      logic        locked;
      logic        restart;
      int          cycles;
      logic [11:0] exp;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input logic l, input logic r, input int c, input logic rb,
                               input logic sr, input logic rd, input logic ft, input logic [7:0] lc);
      vec_t v;
      v.locked = l; v.restart = r; v.cycles = c; v.exp = {rb, sr, rd, ft, lc};
      vecs.push_back(v);
   endfunction

   initial begin
      int   waited;
      logic seen_ready;

      // Lock 5 cycles after RESETB release, drop in S_RUN, restart in S_RUN
      add(1'b0, 1'b0, 15,     1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b0, 1'b0, 1,      1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b0, 1'b0, 4,      1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 1'b0, SC + 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      add(1'b1, 1'b0, 1,      1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      add(1'b0, 1'b0, 2,      1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      add(1'b0, 1'b0, 1,      1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b1, 1'b0, 15,     1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b1, 1'b0, 1,      1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b1, 1'b0, SC,     1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b1, 1'b0, 1,      1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
      add(1'b1, 1'b1, 1,      1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b1, 1'b0, 16,     1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
      // Lock never rises: four attempts then fault, restart clears it
      add(1'b0, 1'b1, 1,      1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
      for (int k = 1; k <= MR + 1; k++) begin
         add(1'b0, 1'b0, RC,     1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
         add(1'b0, 1'b0, LT - 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
         add(1'b0, 1'b0, 1,      1'b0, 1'b0, 1'b0, (k == MR + 1), 8'd1);
      end
      add(1'b0, 1'b0, 50,     1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
      add(1'b0, 1'b1, 1,      1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
      add(1'b0, 1'b0, RC,     1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

      reset_n = 1'b0;
      bus.pll_locked = 1'b0;
      bus.restart = 1'b0;
      model_reset();
      #2;
      check("reset_state", dut_outs(), 12'h000);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         bus.pll_locked = vecs[i].locked;
         bus.restart = vecs[i].restart;
         for (int c = 0; c < vecs[i].cycles; c++) step();
         check($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
      end
      bus.restart = 1'b0;

      // Chattering lock (20 high, 1 low) must time out, never reaching S_RUN
      seen_ready = 1'b0;
      for (int i = 0; i < LT; i++) begin
         bus.pll_locked = ((i % 21) != 20);
         step();
         seen_ready = seen_ready | bus.ready;
      end
      check("chatter_no_run", {11'd0, seen_ready}, 12'd0);
      check("chatter_timeout", {10'd0, bus.pll_resetb, bus.fault}, 12'd0);
      // That timeout used one retry, so three more timeouts reach fault
      bus.pll_locked = 1'b0;
      repeat (MR * (RC + LT)) step();
      check("retry_used_fault", {11'd0, bus.fault}, 12'd1);
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;

      // Repeated 3-cycle lock drops saturate lost_count
      for (int d = 0; d < 300; d++) begin
         bus.pll_locked = 1'b1;
         waited = 0;
         while (!bus.ready && waited < 200) begin
            step();
            waited++;
         end
         check("reach_run", {11'd0, bus.ready}, 12'd1);
         bus.pll_locked = 1'b0;
         repeat (3) step();
      end
      check("lost_saturated", {4'd0, bus.lost_count}, 12'd255);

      // Random lock and restart traffic
      bus.pll_locked = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) bus.pll_locked = ~bus.pll_locked;
         bus.restart = ($urandom_range(0, 399) == 0);
         step();
      end

      // Asynchronous reset in the middle of S_STABLE
      bus.pll_locked = 1'b1;
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      repeat (RC + 4) step();
      check("pre_reset_seek", {11'd0, bus.pll_resetb}, 12'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", dut_outs(), 12'h000);
      model_reset();
      #2;
      reset_n = 1'b1;
      repeat (RC - 1) step();
      check("hold_after_reset", dut_outs(), 12'h000);
      step();
      check("release_after_reset", dut_outs(), 12'h800);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pll_sequencer.md
PLL_SEQUENCER -- requirements
Module: pll_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 16: cycles PLL RESETB is held low per attempt (min 2).
REQ-002 Parameter LOCK_TIMEOUT, default 16000: cycles allowed from release of RESETB to entry of S_RUN (1 ms at 16 MHz).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before S_RUN.
REQ-004 Parameter MAX_RETRIES, default 3: timeouts tolerated before S_FAULT.
REQ-005 clock_in  input  1  16 MHz reference clock; the block's only clock; all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 pll_locked  input  1  PLL LOCK output; asynchronous to clock_in.
REQ-008 restart  input  1  single-cycle request to re-run the sequence.
REQ-009 pll_resetb  output  1  drives PLL RESETB; 0 holds PLL in reset.
REQ-010 sys_reset_n  output  1  active-low reset for the PLL clock domain; downstream synchronizes its deassertion.
REQ-011 ready  output  1  high only in S_RUN.
REQ-012 fault  output  1  high only in S_FAULT.
REQ-013 lost_count  output  8  saturating count of lock losses while in S_RUN.

Function
REQ-014 pll_locked SHALL pass through a two-flop synchronizer; lock_s denotes its output (2-cycle latency).
REQ-015 States SHALL be S_RESET, S_WAIT, S_STABLE, S_RUN, S_FAULT; all outputs registered.
REQ-016 S_RESET: pll_resetb=0, sys_reset_n=0; after exactly RESET_CYCLES cycles go to S_WAIT with timeout timer cleared.
REQ-017 S_WAIT: pll_resetb=1; lock_s=1 -> S_STABLE with stable counter cleared; timer keeps running.
REQ-018 S_STABLE: lock_s=0 -> S_WAIT, stable counter cleared, timer NOT cleared; counter reaching STABLE_CYCLES-1 with lock_s=1 -> S_RUN.
REQ-019 Timer SHALL count every cycle in S_WAIT and S_STABLE; reaching LOCK_TIMEOUT-1 is a timeout and has priority over the S_STABLE->S_RUN transition in the same cycle.
REQ-020 On timeout: retry_cnt<MAX_RETRIES -> increment retry_cnt, go to S_RESET; otherwise go to S_FAULT.
REQ-021 S_RUN: sys_reset_n=1, ready=1; lock_s=0 -> S_RESET, lost_count+1 (saturate at 255), retry_cnt cleared.
REQ-022 S_FAULT: pll_resetb=0, sys_reset_n=0, fault=1; leaves only on restart.
REQ-023 restart=1 in any state SHALL force S_RESET next cycle with retry_cnt and timer cleared; lost_count unchanged; restart has priority over all other transitions.
REQ-024 sys_reset_n SHALL go low the cycle after any departure from S_RUN and never glitch high outside S_RUN.
REQ-025 Counter widths SHALL be clog2 of their parameter (min 1 bit); no counter wraps.

Reset
REQ-026 reset_n low SHALL asynchronously force: state S_RESET, pll_resetb=0, sys_reset_n=0, ready=0, fault=0, lost_count=0, all counters and synchronizer flops 0.
REQ-027 After reset_n deasserts, the sequence SHALL start at S_RESET with a full RESET_CYCLES hold.

Structure
REQ-028 Package pll_seq_pkg SHALL hold the state enumeration and the four default parameter constants.
REQ-029 The synchronizer SHALL be sub-module sync2 (two flops, async active-low reset to 0), instantiated once.

Verification
REQ-030 Lock rises 5 cycles after RESETB release, stays high -> sys_reset_n=1 and ready=1 exactly 2+STABLE_CYCLES cycles after lock_s stable-count start; pll_resetb low for exactly 16 cycles initially.
REQ-031 pll_locked never rises -> 3 retries each with 16-cycle RESETB pulse, then fault=1, pll_resetb=0; restart pulse -> fault=0 next cycle, new attempt.
REQ-032 Lock chatters (500 high, 1 low, repeat) -> never reaches S_RUN, timeout after 16000 cycles, retry_cnt increments.
REQ-033 Lock drops for 3 cycles in S_RUN -> sys_reset_n=0 within 3 cycles of the drop, lost_count=1, full re-sequence to S_RUN; 300 drops -> lost_count=255.
REQ-034 reset_n asserted mid-S_STABLE -> all outputs at reset values immediately (no clock edge), restart from full RESET hold.
REQ-035 restart asserted in S_RUN -> ready=0 and sys_reset_n=0 next cycle, lost_count unchanged.
